// File: rtl/comp_out_misr.sv
// comp_out_misr: compresses a stream of comparator result words into a MISR
// signature. A run skips PIPE_LAT cycles so the upstream pipeline can flush,
// then captures num_cycles words, then holds the result in DONE.
// Optional max tracker: define COMP_OUT_MISR_MAXTRACK_EN so that max_comp
// reports the largest word captured in the run. Without it, max_comp is 0.
// The feedback taps (x^32+x^22+x^2+x+1) assume SIG_WIDTH >= 22.
module comp_out_misr #(
    parameter int IN_WIDTH  = 10,
    parameter int SIG_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter int PIPE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_cycles,
    input  logic [IN_WIDTH-1:0]  comp_out,
    output logic                 busy,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [IN_WIDTH-1:0]  max_comp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The skip counter is loaded with PIPE_LAT-1 and counts down to zero.
    localparam int SKIP_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int SKIP_LOAD = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SKIP_W-1:0]      skip_q, skip_d;
    logic [SIG_WIDTH-1:0]   sig_q, sig_d;
    logic [SIG_WIDTH-1:0]   sig_cap;
    logic                   fb;

    assign fb = sig_q[SIG_WIDTH-1] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0];

    // Next MISR value for one capture: shift in feedback, XOR the
    // zero-extended input word into the low bits.
    for (genvar gi = 0; gi < SIG_WIDTH; gi++) begin : g_cap
        if (gi < IN_WIDTH) begin : g_in
            if (gi == 0) begin : g_lsb
                assign sig_cap[gi] = fb ^ comp_out[gi];
            end else begin : g_mid
                assign sig_cap[gi] = sig_q[gi-1] ^ comp_out[gi];
            end
        end else begin : g_hi
            assign sig_cap[gi] = sig_q[gi-1];
        end
    end

    // Next-state, counter and signature logic for the run sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        sig_d   = sig_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    sig_d  = SIG_WIDTH'(1);
                    cnt_d  = num_cycles;
                    skip_d = SKIP_W'(SKIP_LOAD);
                    if (PIPE_LAT > 0) begin
                        state_d = S_SKIP;
                    end else if (num_cycles == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_SKIP: begin
                busy = 1'b1;
                if (skip_q == '0) begin
                    state_d = (cnt_q == '0) ? S_DONE : S_RUN;
                end else begin
                    skip_d = skip_q - 1'b1;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                sig_d = sig_cap;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any start request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            skip_q  <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            sig_q   <= sig_d;
        end
    end

    assign signature = sig_q;

`ifdef COMP_OUT_MISR_MAXTRACK_EN
    logic [IN_WIDTH-1:0] max_q, max_d;
    logic                start_run;
    logic                capture;

    assign start_run = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign capture   = (state_q == S_RUN);

    // Running unsigned maximum of the words captured in the current run.
    always_comb begin
        max_d = max_q;
        if (start_run) begin
            max_d = '0;
        end else if (capture && (comp_out > max_q)) begin
            max_d = comp_out;
        end
    end

    // Max tracker register.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_comp = max_q;
`else
    assign max_comp = '0;
`endif

endmodule

// File: tb/tb_comp_out_misr.sv
// Directed bench for comp_out_misr: a table of runs with hand-computed
// signatures, plus sequences for restart, mid-run start, reset and the
// full-range capture count.
module tb_comp_out_misr;

    localparam int IN_W  = 10;
    localparam int SIG_W = 32;
    localparam int CNT_W = 16;
    localparam int PL    = 2;
`ifdef COMP_OUT_MISR_MAXTRACK_EN
    localparam bit MT = 1'b1;
`else
    localparam bit MT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_cycles;
    logic [IN_W-1:0]  comp_out;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [IN_W-1:0]  max_comp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comp_out_misr #(
        .IN_WIDTH (IN_W),
        .SIG_WIDTH(SIG_W),
        .CNT_WIDTH(CNT_W),
        .PIPE_LAT (PL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_cycles(num_cycles),
        .comp_out  (comp_out),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .max_comp  (max_comp)
    );

    typedef struct {
        int                   n;
        logic [3:0][IN_W-1:0] c;
        logic [SIG_W-1:0]     sig;
        logic [IN_W-1:0]      mx;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Independent polynomial reference for all-zero input words.
    function automatic logic [SIG_W-1:0] ref_zero(input int n);
        logic [SIG_W-1:0] s;
        s = 32'h1;
        for (int i = 0; i < n; i++) begin
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        end
        return s;
    endfunction

    // Start a run, feed words during RUN, check cycle count, result and hold.
    task automatic run_vec(input string name, input int n, input logic [3:0][IN_W-1:0] c,
                           input logic [SIG_W-1:0] esig, input logic [IN_W-1:0] emax,
                           input int mid_k);
        int k;
        @(negedge clk);
        start      = 1'b1;
        num_cycles = CNT_W'(n);
        comp_out   = IN_W'($urandom);
        @(negedge clk);
        start      = 1'b0;
        num_cycles = CNT_W'($urandom);
        chk($sformatf("%s.done_drop", name), done, 0);
        chk($sformatf("%s.busy_rise", name), busy, 1);
        k = 0;
        while (busy && k < 70000) begin
            if (k >= PL) comp_out = (k - PL < 4) ? c[k-PL] : '0;
            else comp_out = IN_W'($urandom);
            if (k == mid_k) begin
                start      = 1'b1;
                num_cycles = CNT_W'(7);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk($sformatf("%s.busy_cycles", name), k, PL + n);
        chk($sformatf("%s.done", name), done, 1);
        chk($sformatf("%s.sig", name), signature, esig);
        chk($sformatf("%s.max", name), max_comp, emax);
        repeat (3) begin
            comp_out = IN_W'($urandom);
            @(negedge clk);
        end
        chk($sformatf("%s.hold_done", name), done, 1);
        chk($sformatf("%s.hold_sig", name), signature, esig);
        chk($sformatf("%s.hold_max", name), max_comp, emax);
        $display("run %s n=%0d busy_cycles=%0d sig=%08h max=%0d", name, n, k, signature, max_comp);
    endtask

    initial begin
        // n, words (c3..c0), expected signature, expected max when tracking
        vecs[0] = '{n: 1, c: {10'd0, 10'd0, 10'd0, 10'd0},        sig: 32'h0000_0003, mx: 10'd0};
        vecs[1] = '{n: 2, c: {10'd0, 10'd0, 10'd0, 10'd0},        sig: 32'h0000_0006, mx: 10'd0};
        vecs[2] = '{n: 1, c: {10'd0, 10'd0, 10'd0, 10'h3FF},      sig: 32'h0000_03FC, mx: 10'h3FF};
        vecs[3] = '{n: 0, c: {10'd0, 10'd0, 10'd0, 10'd0},        sig: 32'h0000_0001, mx: 10'd0};
        vecs[4] = '{n: 3, c: {10'd0, 10'd17, 10'd300, 10'd5},     sig: 32'h0000_0252, mx: 10'd300};
        vecs[5] = '{n: 2, c: {10'd0, 10'd0, 10'd2, 10'd1},        sig: 32'h0000_0007, mx: 10'd2};

        reset      = 1'b1;
        start      = 1'b0;
        num_cycles = '0;
        comp_out   = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.sig", signature, 0);
        chk("reset.max", max_comp, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.busy", busy, 0);
        $display("reset sequence complete");

        // Table runs back to back: each run after the first starts from DONE.
        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].n, vecs[i].c, vecs[i].sig,
                    MT ? vecs[i].mx : 10'd0, -1);
        end

        // start pulsed in the second RUN cycle is ignored.
        run_vec("mid_start", 3, {10'd0, 10'd17, 10'd300, 10'd5}, 32'h0000_0252,
                MT ? 10'd300 : 10'd0, PL + 1);

        // Reset during the third RUN cycle of a 10-capture run.
        begin
            int k;
            @(negedge clk);
            start      = 1'b1;
            num_cycles = CNT_W'(10);
            @(negedge clk);
            start = 1'b0;
            k = 0;
            while (k < PL + 2) begin
                comp_out = IN_W'($urandom_range(1, 1023));
                @(negedge clk);
                k++;
            end
            chk("rst_mid.busy_before", busy, 1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_mid.busy", busy, 0);
            chk("rst_mid.done", done, 0);
            chk("rst_mid.sig", signature, 0);
            chk("rst_mid.max", max_comp, 0);
            @(negedge clk);
            chk("rst_mid.stay_idle", busy, 0);
            $display("reset mid-run sig=%08h busy=%0d", signature, busy);
        end

        // Normal run after the mid-run reset.
        run_vec("after_rst", 2, {10'd0, 10'd0, 10'd2, 10'd1}, 32'h0000_0007,
                MT ? 10'd2 : 10'd0, -1);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        reset      = 1'b1;
        start      = 1'b1;
        num_cycles = CNT_W'(4);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start.busy", busy, 0);
        chk("rst_start.done", done, 0);
        chk("rst_start.sig", signature, 0);
        @(negedge clk);
        chk("rst_start.busy_next", busy, 0);
        $display("reset with start busy=%0d sig=%08h", busy, signature);

        // Full-range count: 2^CNT_W-1 captures with no wrap.
        run_vec("full_cnt", (1 << CNT_W) - 1, {10'd0, 10'd0, 10'd0, 10'd0},
                ref_zero((1 << CNT_W) - 1), 10'd0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
